// File: rtl/hallway_tracer_controller.sv
// -----------------------------------------------------------------------------
// hallway_tracer_controller
//
// Sequences the hallway tracer datapath. Each gameTick received in WAIT
// launches STEPS_PER_TICK pairs of one-cycle move pulses (upper first, then
// lower). Each pulse is issued only when it keeps the tracer inside its
// position bounds and keeps the hallway gap (lower - upper) at or above
// MIN_GAP. A blocked move still uses up its cycle and its step.
// The random tick generator is seeded once per run, and a gameTick that
// arrives while a sequence is running is reported on tickOverrun and dropped.
//
// Ports:
//   clock                   system clock, all state on the rising edge
//   reset_n                 asynchronous active-low reset
//   start                   begin a run (sampled in IDLE)
//   stop                    end a run (latched, honoured in WAIT)
//   gameTick                one-cycle game tick pulse
//   upperTracerPos [6:0]    current upper tracer position
//   lowerTracerPos [6:0]    current lower tracer position
//   upperTracerDir          1 = move down (inc), 0 = move up (dec)
//   lowerTracerDir          same encoding for the lower tracer
//   resetNumberGenerator    one-cycle seed pulse (SEED state)
//   inc/dec_upperHallTracerPos, inc/dec_lowerHallTracerPos  move pulses
//   busy                    high while a move sequence runs
//   tickOverrun             one-cycle pulse when a gameTick is dropped
// -----------------------------------------------------------------------------
module hallway_tracer_controller #(
    parameter int unsigned STEPS_PER_TICK = 2,
    parameter int unsigned MIN_GAP        = 24,
    parameter int unsigned UPPER_MIN      = 0,
    parameter int unsigned UPPER_MAX      = 93,
    parameter int unsigned LOWER_MIN      = 26,
    parameter int unsigned LOWER_MAX      = 119
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       gameTick,
    input  logic [6:0] upperTracerPos,
    input  logic [6:0] lowerTracerPos,
    input  logic       upperTracerDir,
    input  logic       lowerTracerDir,
    output logic       resetNumberGenerator,
    output logic       inc_upperHallTracerPos,
    output logic       dec_upperHallTracerPos,
    output logic       inc_lowerHallTracerPos,
    output logic       dec_lowerHallTracerPos,
    output logic       busy,
    output logic       tickOverrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_UPPER = 3'd3,
        ST_LOWER = 3'd4
    } state_t;

    localparam logic        [3:0] L_LAST_STEP = 4'(STEPS_PER_TICK - 1);
    localparam logic signed [7:0] L_MIN_GAP   = 8'(MIN_GAP);
    localparam logic        [6:0] L_UPPER_MIN = 7'(UPPER_MIN);
    localparam logic        [6:0] L_UPPER_MAX = 7'(UPPER_MAX);
    localparam logic        [6:0] L_LOWER_MIN = 7'(LOWER_MIN);
    localparam logic        [6:0] L_LOWER_MAX = 7'(LOWER_MAX);

    state_t     r_state;
    logic [3:0] r_step_cnt;
    logic       r_stop_pending;

    // Gap after a prospective move. Both differences are taken in 8-bit signed
    // arithmetic so that crossed tracers (negative gap) always block the move.
    logic signed [7:0] w_gap_after_upper_inc;
    logic signed [7:0] w_gap_after_lower_dec;
    logic              w_upper_inc_ok;
    logic              w_upper_dec_ok;
    logic              w_lower_inc_ok;
    logic              w_lower_dec_ok;

    // Legality of each of the four candidate moves for the current positions.
    always_comb begin
        w_gap_after_upper_inc = $signed({1'b0, lowerTracerPos})
                              - $signed({1'b0, upperTracerPos}) - 8'sd1;
        w_gap_after_lower_dec = $signed({1'b0, lowerTracerPos}) - 8'sd1
                              - $signed({1'b0, upperTracerPos});
        w_upper_inc_ok = (upperTracerPos < L_UPPER_MAX)
                       && (w_gap_after_upper_inc >= L_MIN_GAP);
        w_upper_dec_ok = (upperTracerPos > L_UPPER_MIN);
        w_lower_inc_ok = (lowerTracerPos < L_LOWER_MAX);
        w_lower_dec_ok = (lowerTracerPos > L_LOWER_MIN)
                       && (w_gap_after_lower_dec >= L_MIN_GAP);
    end

    // Controller FSM: state, step counter and latched stop request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_step_cnt     <= 4'd0;
            r_stop_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // stop is meaningless while idle, so it is not latched here
                    if (start) begin
                        r_state <= ST_SEED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEED: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end else begin
                        r_stop_pending <= r_stop_pending;
                    end
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // a stop request wins over a simultaneous tick
                    if (r_stop_pending || stop) begin
                        r_state        <= ST_IDLE;
                        r_stop_pending <= 1'b0;
                    end else if (gameTick) begin
                        r_state    <= ST_UPPER;
                        r_step_cnt <= 4'd0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_UPPER: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end else begin
                        r_stop_pending <= r_stop_pending;
                    end
                    r_state <= ST_LOWER;
                end
                ST_LOWER: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end else begin
                        r_stop_pending <= r_stop_pending;
                    end
                    if (r_step_cnt == L_LAST_STEP) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_step_cnt <= r_step_cnt + 4'd1;
                        r_state    <= ST_UPPER;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_step_cnt     <= 4'd0;
                    r_stop_pending <= 1'b0;
                end
            endcase
        end
    end

    // Output decode from the state register; only one tracer state is active
    // at a time and direction selects inc or dec, so moves are mutually
    // exclusive by construction.
    always_comb begin
        resetNumberGenerator   = 1'b0;
        inc_upperHallTracerPos = 1'b0;
        dec_upperHallTracerPos = 1'b0;
        inc_lowerHallTracerPos = 1'b0;
        dec_lowerHallTracerPos = 1'b0;
        busy                   = 1'b0;
        tickOverrun            = 1'b0;
        case (r_state)
            ST_SEED: begin
                resetNumberGenerator = 1'b1;
            end
            ST_UPPER: begin
                busy        = 1'b1;
                tickOverrun = gameTick;
                if (upperTracerDir) begin
                    inc_upperHallTracerPos = w_upper_inc_ok;
                end else begin
                    dec_upperHallTracerPos = w_upper_dec_ok;
                end
            end
            ST_LOWER: begin
                busy        = 1'b1;
                tickOverrun = gameTick;
                if (lowerTracerDir) begin
                    inc_lowerHallTracerPos = w_lower_inc_ok;
                end else begin
                    dec_lowerHallTracerPos = w_lower_dec_ok;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hallway_tracer_controller.sv
module tb_hallway_tracer_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       gameTick;
    logic [6:0] upperTracerPos;
    logic [6:0] lowerTracerPos;
    logic       upperTracerDir;
    logic       lowerTracerDir;
    logic       rng;
    logic       iu, du, il, dl;
    logic       busy;
    logic       ovr;

    logic       ld;
    logic [6:0] ld_up;
    logic [6:0] ld_lo;

    int n_chk  = 0;
    int n_pass = 0;
    int c_rng, c_iu, c_du, c_il, c_dl, c_busy, c_ovr;
    int c_multi = 0;
    logic [3:0] seq_q[$];

    always #5 clock = ~clock;

    hallway_tracer_controller dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .start                 (start),
        .stop                  (stop),
        .gameTick              (gameTick),
        .upperTracerPos        (upperTracerPos),
        .lowerTracerPos        (lowerTracerPos),
        .upperTracerDir        (upperTracerDir),
        .lowerTracerDir        (lowerTracerDir),
        .resetNumberGenerator  (rng),
        .inc_upperHallTracerPos(iu),
        .dec_upperHallTracerPos(du),
        .inc_lowerHallTracerPos(il),
        .dec_lowerHallTracerPos(dl),
        .busy                  (busy),
        .tickOverrun           (ovr)
    );

    // Tracer position registers of the datapath, driven by the move pulses.
    always @(posedge clock) begin
        if (ld) begin
            upperTracerPos <= ld_up;
            lowerTracerPos <= ld_lo;
        end else begin
            if (iu)      upperTracerPos <= upperTracerPos + 7'd1;
            else if (du) upperTracerPos <= upperTracerPos - 7'd1;
            if (il)      lowerTracerPos <= lowerTracerPos + 7'd1;
            else if (dl) lowerTracerPos <= lowerTracerPos - 7'd1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One controller cycle: sample outputs mid-cycle, then step past the edge.
    task automatic cyc();
        logic [3:0] mv;
        @(negedge clock);
        mv = {iu, du, il, dl};
        c_rng  += int'(rng);
        c_iu   += int'(iu);
        c_du   += int'(du);
        c_il   += int'(il);
        c_dl   += int'(dl);
        c_busy += int'(busy);
        c_ovr  += int'(ovr);
        if ($countones(mv) > 1) c_multi++;
        if (busy) seq_q.push_back(mv);
        @(posedge clock);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic clr();
        c_rng = 0; c_iu = 0; c_du = 0; c_il = 0; c_dl = 0;
        c_busy = 0; c_ovr = 0;
        seq_q.delete();
    endtask

    task automatic load(input logic [6:0] u, input logic [6:0] l);
        ld = 1'b1; ld_up = u; ld_lo = l;
        cyc();
        ld = 1'b0;
    endtask

    task automatic run_seq();
        clr();
        gameTick = 1'b1;
        cyc();
        gameTick = 1'b0;
        cycn(6);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; gameTick = 1'b0;
        upperTracerDir = 1'b1; lowerTracerDir = 1'b1;
        ld = 1'b1; ld_up = 7'd40; ld_lo = 7'd80;
        clr();
        cycn(2);
        chk("reset_outputs", int'({rng, iu, du, il, dl, busy, ovr}), 0);
        ld = 1'b0;
        reset_n = 1'b1;
        cycn(2);
        chk("idle_no_seed", c_rng, 0);

        // start -> one seed cycle, then WAIT with no moves
        clr();
        start = 1'b1; cyc(); start = 1'b0;
        cycn(4);
        chk("seed_pulses", c_rng, 1);
        chk("seed_no_moves", c_iu + c_du + c_il + c_dl, 0);
        chk("seed_no_busy", c_busy, 0);

        // free movement: inc_u, inc_l, inc_u, inc_l
        load(7'd40, 7'd80);
        upperTracerDir = 1'b1; lowerTracerDir = 1'b1;
        run_seq();
        chk("free_len", seq_q.size(), 4);
        if (seq_q.size() == 4) begin
            chk("free_c0", int'(seq_q[0]), 8);
            chk("free_c1", int'(seq_q[1]), 2);
            chk("free_c2", int'(seq_q[2]), 8);
            chk("free_c3", int'(seq_q[3]), 2);
        end
        chk("free_up", int'(upperTracerPos), 42);
        chk("free_lo", int'(lowerTracerPos), 82);
        chk("free_busy", c_busy, 4);
        chk("free_ovr", c_ovr, 0);

        // gap 24 exactly: every move blocked
        load(7'd56, 7'd80);
        upperTracerDir = 1'b1; lowerTracerDir = 1'b0;
        run_seq();
        chk("gap_moves", c_iu + c_du + c_il + c_dl, 0);
        chk("gap_busy", c_busy, 4);
        chk("gap_up", int'(upperTracerPos), 56);
        chk("gap_lo", int'(lowerTracerPos), 80);

        // gap 25: one upper inc allowed, then blocked
        load(7'd55, 7'd80);
        run_seq();
        chk("gap25_iu", c_iu, 1);
        chk("gap25_dl", c_dl, 0);
        chk("gap25_up", int'(upperTracerPos), 56);

        // bounds: already at limits
        load(7'd0, 7'd119);
        upperTracerDir = 1'b0; lowerTracerDir = 1'b1;
        run_seq();
        chk("bound_du", c_du, 0);
        chk("bound_il", c_il, 0);
        chk("bound_busy", c_busy, 4);

        // bounds: one step from limits
        load(7'd1, 7'd118);
        run_seq();
        chk("edge_du", c_du, 1);
        chk("edge_il", c_il, 1);
        chk("edge_up", int'(upperTracerPos), 0);
        chk("edge_lo", int'(lowerTracerPos), 119);

        // crossed tracers: negative gap blocks both
        load(7'd50, 7'd30);
        upperTracerDir = 1'b1; lowerTracerDir = 1'b0;
        run_seq();
        chk("neg_moves", c_iu + c_dl, 0);

        // overrun: second tick 2 cycles after the first
        load(7'd40, 7'd80);
        upperTracerDir = 1'b1; lowerTracerDir = 1'b1;
        clr();
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        cyc();
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        cycn(6);
        chk("ovr_pulses", c_ovr, 1);
        chk("ovr_busy", c_busy, 4);
        chk("ovr_moves", c_iu + c_il, 4);
        chk("ovr_up", int'(upperTracerPos), 42);

        // stop during UPPER: sequence completes, then exit to IDLE
        clr();
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;
        cycn(3);
        cyc();
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        cycn(6);
        chk("stop_busy", c_busy, 4);
        chk("stop_ovr", c_ovr, 0);
        chk("stop_up", int'(upperTracerPos), 44);
        clr();
        start = 1'b1; cyc(); start = 1'b0;
        cycn(2);
        chk("restart_seed", c_rng, 1);

        // stop in WAIT beats a simultaneous tick
        clr();
        stop = 1'b1; gameTick = 1'b1; cyc(); stop = 1'b0; gameTick = 1'b0;
        cycn(2);
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        cycn(6);
        chk("stopw_busy", c_busy, 0);
        chk("stopw_ovr", c_ovr, 0);

        // reset during LOWER
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        cyc();
        chk("pre_rst_busy", int'(busy), 1);
        gameTick = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", int'({rng, iu, du, il, dl, busy, ovr}), 0);
        gameTick = 1'b0;
        cycn(2);
        reset_n = 1'b1;
        clr();
        cyc();
        run_seq();
        chk("post_rst_idle", c_busy, 0);
        clr();
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        gameTick = 1'b1; cyc(); gameTick = 1'b0;
        cycn(6);
        chk("post_rst_seed", c_rng, 1);
        chk("post_rst_busy", c_busy, 4);

        chk("one_hot_moves", c_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
